// File: rtl/tr_prefetch_buff.sv
// tr_prefetch_buff: reads frame pixels from SRAM ahead of need into a small FIFO,
// so the VGA controller can pop one pixel per request without seeing SRAM latency.
module tr_prefetch_buff #(
    parameter int addr_bus_size = 16,
    parameter int data_bus_size = 16,
    parameter int pix_w         = 12,
    parameter int depth         = 8,
    parameter int base_addr     = 0,
    parameter int frame_pixels  = 19200
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_frame_start,
    input  logic                     i_pix_req,
    input  logic                     i_blank,
    input  logic                     i_ready,
    input  logic [data_bus_size-1:0] i_sram_data,
    output logic [addr_bus_size-1:0] o_sram_addr,
    output logic [data_bus_size-1:0] o_dummy_data,
    output logic                     o_start,
    output logic                     o_rw,
    output logic [pix_w-1:0]         o_data_out,
    output logic [$clog2(depth):0]   o_level,
    output logic                     o_underrun
);
    localparam int PW = $clog2(depth);
    localparam int LW = PW + 1;
    localparam logic [addr_bus_size-1:0] BASE = addr_bus_size'(base_addr);
    localparam logic [addr_bus_size-1:0] LAST = addr_bus_size'(base_addr + frame_pixels - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                   r_state;
    logic                     r_start;
    logic                     r_drain;
    logic [addr_bus_size-1:0] r_rd_addr;
    logic [pix_w-1:0]         r_mem [depth];
    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_rptr;
    logic [LW-1:0]            r_level;
    logic [pix_w-1:0]         r_data_out;
    logic                     r_underrun;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_req;
    logic                     w_not_full;

    // frame_start overrides both sides: no pop, and an in-flight read is dropped
    assign w_req      = i_pix_req && !i_blank && !i_frame_start;
    assign w_pop      = w_req && (r_level != '0);
    assign w_push     = (r_state == WAIT) && i_ready && !r_drain && !i_frame_start;
    assign w_not_full = r_level < LW'(depth);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_start   <= 1'b1;
            r_drain   <= 1'b0;
            r_rd_addr <= BASE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_frame_start || w_not_full) begin
                        r_state <= ISSUE;
                        r_start <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                    r_start <= 1'b1;
                    if (i_frame_start) r_drain <= 1'b1;
                end
                WAIT: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                        r_drain <= 1'b0;
                    end else if (i_frame_start) begin
                        r_drain <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_start <= 1'b1;
                end
            endcase
            if (i_frame_start) r_rd_addr <= BASE;
            else if (w_push) r_rd_addr <= (r_rd_addr == LAST) ? BASE : r_rd_addr + addr_bus_size'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_sram_data[pix_w-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_frame_start) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // an empty pop still reads as a request: output 0 and flag the underrun
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_frame_start) begin
            r_data_out <= '0;
            r_underrun <= 1'b0;
        end else if (i_blank) begin
            r_data_out <= '0;
        end else if (i_pix_req) begin
            r_data_out <= w_pop ? r_mem[r_rptr] : '0;
            r_underrun <= r_underrun || !w_pop;
        end
    end

    generate
        if (pix_w < data_bus_size) begin : g_pad
            logic w_unused;
            assign w_unused = ^i_sram_data[data_bus_size-1:pix_w];
        end
    endgenerate

    assign o_sram_addr  = r_rd_addr;
    assign o_dummy_data = '0;
    assign o_start      = r_start;
    assign o_rw         = 1'b1;
    assign o_data_out   = r_data_out;
    assign o_level      = r_level;
    assign o_underrun   = r_underrun;
endmodule

// File: tb/tb_tr_prefetch_buff.sv
// tb_tr_prefetch_buff: drives tr_prefetch_buff through an SRAM responder and checks
// every cycle against a queue-based model, plus vector tables and corner sequences.
module tb_tr_prefetch_buff;
    localparam int AW = 16, DW = 16, PW = 12, DEPTH = 8, BASE = 0, FP = 12;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, fs = 1'b0, preq = 1'b0, blank = 1'b0, ready = 1'b0;
    logic [DW-1:0] sdata = '0;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] dummy;
    logic          start, rw, unr;
    logic [PW-1:0] dout;
    logic [LW-1:0] level;

    tr_prefetch_buff #(
        .addr_bus_size(AW), .data_bus_size(DW), .pix_w(PW),
        .depth(DEPTH), .base_addr(BASE), .frame_pixels(FP)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .i_frame_start(fs), .i_pix_req(preq),
        .i_blank(blank), .i_ready(ready), .i_sram_data(sdata),
        .o_sram_addr(sram_addr), .o_dummy_data(dummy), .o_start(start), .o_rw(rw),
        .o_data_out(dout), .o_level(level), .o_underrun(unr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // inputs and start as seen by the DUT at each rising edge
    logic s_rst = 1'b0, s_fs = 1'b0, s_preq = 1'b0, s_blank = 1'b0, s_ready = 1'b0, s_start = 1'b1;
    always @(posedge clk) begin
        s_rst   <= rst_n;
        s_fs    <= fs;
        s_preq  <= preq;
        s_blank <= blank;
        s_ready <= ready;
        s_start <= start;
    end

    logic [PW-1:0] q[$];
    int            m_addr = BASE;
    bit            m_out = 0, m_drain = 0, m_unr = 0;
    logic [PW-1:0] m_dout = '0;
    bit            hold = 0, pend = 0;
    int            lat_min = 2, lat_max = 2, cnt = 0;
    logic [AW-1:0] paddr = '0;

    always @(negedge clk) begin
        if (!s_rst) begin
            q.delete();
            m_addr = BASE; m_out = 0; m_drain = 0; m_unr = 0; m_dout = '0;
        end else begin
            if (s_fs) begin
                q.delete(); m_dout = '0; m_unr = 0;
            end else if (s_blank) begin
                m_dout = '0;
            end else if (s_preq) begin
                if (q.size() != 0) m_dout = q.pop_front();
                else begin m_dout = '0; m_unr = 1; end
            end
            if (s_ready) begin
                if (!m_drain && !s_fs) begin
                    q.push_back(PW'(32'hABC + m_addr));
                    m_addr = BASE + (m_addr - BASE + 1) % FP;
                end
                m_out = 0; m_drain = 0;
            end
            if (!s_start) m_out = 1;
            if (s_fs) begin
                m_addr = BASE;
                if (m_out) m_drain = 1;
            end
        end
        chk("data_out", dout, m_dout);
        chk("level", level, q.size());
        chk("underrun", unr, m_unr);
        if (!s_rst) chk("start_in_reset", start, 1);
        ready = 1'b0;
        sdata = DW'($urandom);
        if (!s_rst) pend = 0;
        else begin
            if (pend && !hold) begin
                if (cnt == 0) begin
                    ready = 1'b1; sdata = 16'hFABC + paddr; pend = 0;
                end else cnt--;
            end
            if (!start) begin
                chk("issue_addr", sram_addr, m_addr);
                chk("issue_not_full", q.size() < DEPTH, 1);
                pend = 1; paddr = sram_addr; cnt = $urandom_range(lat_max - 1, lat_min - 1);
            end
        end
    end

    int            nstart = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!start) begin nstart++; last_addr = sram_addr; end
        end
    endtask

    task automatic wait_start(input int lim);
        bit seen = 0;
        for (int i = 0; i < lim && !seen; i++) begin
            tick(1);
            seen = !start;
        end
        chk("start_seen", seen, 1);
    endtask

    task automatic chk_reset_outs();
        chk("rst_start", start, 1);
        chk("rst_level", level, 0);
        chk("rst_dout", dout, 0);
        chk("rst_underrun", unr, 0);
        chk("rst_addr", sram_addr, BASE);
        chk("rw", rw, 1);
        chk("dummy", dummy, 0);
    endtask

    typedef struct {
        logic          preq, blank, fs;
        logic [PW-1:0] dout;
        int            lvl;
        logic          unr;
    } vec_t;
    vec_t tbl[15];
    int   pct[5] = '{10, 40, 70, 5, 90};

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'hABF, 7, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 12'hABF, 7, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 12'h000, 7, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 12'hAC0, 6, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 12'hAC1, 5, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 12'hAC2, 4, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'hAC2, 4, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 12'hAC3, 3, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 12'hAC4, 2, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 12'hAC5, 1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 12'hAC6, 0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 12'h000, 0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 12'h000, 0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 12'h000, 0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 12'h000, 0, 1'b0};

        tick(3);
        chk_reset_outs();
        rst_n = 1'b1;

        // fill from reset: eight reads at 0..7, then nothing while full
        nstart = 0;
        tick(80);
        chk("fill_starts", nstart, 8);
        chk("fill_last_addr", last_addr, 7);
        chk("fill_level", level, 8);

        // three pops from a full FIFO trigger refills at 8..10
        nstart = 0;
        for (int k = 0; k < 3; k++) begin
            preq = 1'b1;
            tick(1);
            preq = 1'b0;
            chk("pop_data", dout, 32'hABC + k);
            tick(6);
        end
        tick(20);
        chk("refill_starts", nstart, 3);
        chk("refill_last_addr", last_addr, 10);
        chk("refill_level", level, 8);

        // drain with the refill read withheld, then flush it with frame_start
        hold = 1;
        foreach (tbl[i]) begin
            preq = tbl[i].preq; blank = tbl[i].blank; fs = tbl[i].fs;
            tick(1);
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_underrun", i), unr, tbl[i].unr);
        end
        preq = 1'b0; blank = 1'b0; fs = 1'b0;
        hold = 0;
        wait_start(20);
        chk("restart_addr", sram_addr, BASE);
        chk("restart_level", level, 0);
        tick(30);
        preq = 1'b1;
        tick(1);
        preq = 1'b0;
        chk("restart_data", dout, 12'hABC);

        // reset while a read is outstanding
        tick(40);
        hold = 1;
        preq = 1'b1;
        tick(1);
        preq = 1'b0;
        chk("pre_reset_data", dout, 12'hABD);
        wait_start(10);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk_reset_outs();
        rst_n = 1'b1;
        hold = 0;

        // randomized traffic against the model
        for (int c = 0; c < 5; c++) begin
            lat_min = 1;
            lat_max = 1 + c % 3;
            for (int i = 0; i < 500; i++) begin
                preq  = ($urandom_range(99, 0) < pct[c]);
                blank = ($urandom_range(9, 0) == 0);
                fs    = ($urandom_range(299, 0) == 0);
                tick(1);
            end
        end
        preq = 1'b0; blank = 1'b0; fs = 1'b0;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
